// File: rtl/mac_argmax_if.sv
// -----------------------------------------------------------------------------
// mac_argmax_if
// Handshake bundle between the upstream MAC stage, the arg-max block and the
// downstream result consumer.
//
// Parameters
//   SW : width of the incoming MAC sum
//   AW : width of the accumulated class score
//
// Signals
//   s_valid      : upstream -> block, s carries a valid MAC sum
//   s            : upstream -> block, unsigned MAC sum [SW-1:0]
//   s_ready      : block -> upstream, block accepts s this cycle
//   result_valid : block -> consumer, result_class/result_score valid
//   result_ready : consumer -> block, consumer takes the result
//   result_class : block -> consumer, index of the winning class [3:0]
//   result_score : block -> consumer, score of the winning class [AW-1:0]
//
// Modports
//   master : the environment side (drives the beats, consumes the result)
//   slave  : the mac_argmax block
// -----------------------------------------------------------------------------
interface mac_argmax_if #(
    parameter int SW = 20,
    parameter int AW = 24
);
    logic          s_valid;
    logic [SW-1:0] s;
    logic          s_ready;
    logic          result_valid;
    logic          result_ready;
    logic [3:0]    result_class;
    logic [AW-1:0] result_score;

    modport master (
        output s_valid,
        output s,
        output result_ready,
        input  s_ready,
        input  result_valid,
        input  result_class,
        input  result_score
    );

    modport slave (
        input  s_valid,
        input  s,
        input  result_ready,
        output s_ready,
        output result_valid,
        output result_class,
        output result_score
    );
endinterface

// File: rtl/mac_argmax.sv
// -----------------------------------------------------------------------------
// mac_argmax
// Accumulates CHUNKS consecutive MAC sums into one class score, scans CLASSES
// class scores per image and presents the index and score of the largest one.
// Ties keep the lower class index. After the last beat of an image the block
// holds the result (and refuses new beats) until the consumer takes it.
//
// Parameters
//   SW      : width of the incoming MAC sum (20)
//   AW      : width of the accumulator / class score, must be >= SW (24)
//   CHUNKS  : MAC sums per class score, 1..16 (1)
//   CLASSES : class scores per image, 2..16 (10)
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mac_argmax_if.slave
//         s_valid/s/s_ready                       beat input handshake
//         result_valid/result_ready               result output handshake
//         result_class/result_score               winning class and its score
//
// Build option
//   ACC_SAT_EN : when defined, the accumulator saturates at 2^AW-1;
//                otherwise it wraps modulo 2^AW without any indication.
// -----------------------------------------------------------------------------
module mac_argmax #(
    parameter int SW      = 20,
    parameter int AW      = 24,
    parameter int CHUNKS  = 1,
    parameter int CLASSES = 10
) (
    input  logic         clk,
    input  logic         rst,
    mac_argmax_if.slave  bus
);

    typedef enum logic {
        ST_ACCUM = 1'b0,  // taking beats, s_ready=1
        ST_HOLD  = 1'b1   // presenting result, result_valid=1
    } state_t;

    // Both counters fit in 4 bits because CHUNKS and CLASSES are at most 16.
    localparam logic [3:0] LAST_CHUNK = 4'(CHUNKS - 1);
    localparam logic [3:0] LAST_CLASS = 4'(CLASSES - 1);

    state_t        r_state;
    logic          r_s_ready;
    logic          r_result_valid;
    logic [AW-1:0] r_acc;
    logic [3:0]    r_chunk;
    logic [3:0]    r_class;
    logic [AW-1:0] r_best;
    logic [3:0]    r_best_class;
    logic [AW-1:0] r_result_score;
    logic [3:0]    r_result_class;

    logic          w_accept;
    logic [AW:0]   w_sum_wide;
    logic [AW-1:0] w_sum;
    logic          w_last_chunk;
    logic          w_last_class;
    logic          w_take;
    logic [AW-1:0] w_win_score;
    logic [3:0]    w_win_class;

    // r_s_ready is high exactly in ST_ACCUM, so this is the accept condition.
    assign w_accept = r_s_ready && bus.s_valid;

    // One extra bit keeps the carry so overflow is visible to the saturating
    // build; the wrapping build just drops it.
    assign w_sum_wide = {1'b0, r_acc} + (AW + 1)'(bus.s);

`ifdef ACC_SAT_EN
    assign w_sum = w_sum_wide[AW] ? {AW{1'b1}} : w_sum_wide[AW-1:0];
`else
    assign w_sum = w_sum_wide[AW-1:0];
`endif

    assign w_last_chunk = (r_chunk == LAST_CHUNK);
    assign w_last_class = (r_class == LAST_CLASS);

    // Class 0 seeds the running best so nothing from a previous image leaks
    // in; later classes need a strictly larger score, so ties keep the
    // lower index.
    assign w_take      = (r_class == 4'd0) || (w_sum > r_best);
    assign w_win_score = w_take ? w_sum   : r_best;
    assign w_win_class = w_take ? r_class : r_best_class;

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of the
    // order of statements in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_ACCUM;
            r_s_ready      <= 1'b1;
            r_result_valid <= 1'b0;
            r_acc          <= '0;
            r_chunk        <= '0;
            r_class        <= '0;
            r_best         <= '0;
            r_best_class   <= '0;
            r_result_score <= '0;
            r_result_class <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    // Without an accepted beat every register keeps its value.
                    if (w_accept) begin
                        if (!w_last_chunk) begin
                            r_acc   <= w_sum;
                            r_chunk <= r_chunk + 4'd1;
                        end else begin
                            // Class score completes this cycle: fold it into
                            // the running best and restart the accumulator.
                            r_acc        <= '0;
                            r_chunk      <= '0;
                            r_best       <= w_win_score;
                            r_best_class <= w_win_class;
                            if (w_last_class) begin
                                r_class        <= '0;
                                r_result_score <= w_win_score;
                                r_result_class <= w_win_class;
                                r_state        <= ST_HOLD;
                                r_s_ready      <= 1'b0;
                                r_result_valid <= 1'b1;
                            end else begin
                                r_class <= r_class + 4'd1;
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    // s is ignored here; the result stays put until taken.
                    // s_ready returns only on the cycle after the handshake.
                    if (bus.result_ready) begin
                        r_state        <= ST_ACCUM;
                        r_s_ready      <= 1'b1;
                        r_result_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= ST_ACCUM;
                    r_s_ready      <= 1'b1;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready      = r_s_ready;
    assign bus.result_valid = r_result_valid;
    assign bus.result_class = r_result_class;
    assign bus.result_score = r_result_score;

endmodule

// File: tb/tb_mac_argmax.sv
// -----------------------------------------------------------------------------
// tb_mac_argmax
// Directed self-checking bench for mac_argmax. Three instances cover the
// configurations of interest:
//   dut_a : SW=20 AW=24 CHUNKS=1 CLASSES=10
//   dut_b : SW=20 AW=24 CHUNKS=4 CLASSES=2
//   dut_c : SW=20 AW=20 CHUNKS=2 CLASSES=2  (overflow behaviour, ACC_SAT_EN)
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_mac_argmax;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    mac_argmax_if #(.SW(20), .AW(24)) ifa ();
    mac_argmax_if #(.SW(20), .AW(24)) ifb ();
    mac_argmax_if #(.SW(20), .AW(20)) ifc ();

    mac_argmax #(.SW(20), .AW(24), .CHUNKS(1), .CLASSES(10)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mac_argmax #(.SW(20), .AW(24), .CHUNKS(4), .CLASSES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    mac_argmax #(.SW(20), .AW(20), .CHUNKS(2), .CLASSES(2)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat presented for exactly one edge (block is in ACCUM).
    task automatic send_a(input logic [19:0] v);
        ifa.s_valid = 1'b1;
        ifa.s       = v;
        tick();
        ifa.s_valid = 1'b0;
    endtask

    task automatic send_a_gap(input logic [19:0] v);
        int gap;
        gap = int'($urandom_range(0, 1));
        repeat (gap) tick();
        send_a(v);
    endtask

    task automatic send_b(input logic [19:0] v);
        ifb.s_valid = 1'b1;
        ifb.s       = v;
        tick();
        ifb.s_valid = 1'b0;
    endtask

    task automatic send_c(input logic [19:0] v);
        ifc.s_valid = 1'b1;
        ifc.s       = v;
        tick();
        ifc.s_valid = 1'b0;
    endtask

    task automatic consume_a();
        ifa.result_ready = 1'b1;
        tick();
        ifa.result_ready = 1'b0;
    endtask

    logic [19:0] img [10];
    logic [31:0] exp_c;

    initial begin
        img = '{20'd5, 20'd9, 20'd3, 20'd9, 20'd0, 20'd1, 20'd2, 20'd8, 20'd7, 20'd6};

        ifa.s_valid = 1'b0; ifa.s = '0; ifa.result_ready = 1'b0;
        ifb.s_valid = 1'b0; ifb.s = '0; ifb.result_ready = 1'b0;
        ifc.s_valid = 1'b0; ifc.s = '0; ifc.result_ready = 1'b0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_s_ready",  32'(ifa.s_ready),      32'd1);
        check("rst_rvalid",   32'(ifa.result_valid), 32'd0);
        check("rst_class",    32'(ifa.result_class), 32'd0);
        check("rst_score",    32'(ifa.result_score), 32'd0);

        // ---------------- back-to-back image, tie resolves low ----------------
        for (int i = 0; i < 9; i++) send_a(img[i]);
        check("b2b_rvalid_before_last", 32'(ifa.result_valid), 32'd0);
        check("b2b_ready_before_last",  32'(ifa.s_ready),      32'd1);
        send_a(img[9]);
        check("b2b_rvalid", 32'(ifa.result_valid), 32'd1);
        check("b2b_ready",  32'(ifa.s_ready),      32'd0);
        check("b2b_class",  32'(ifa.result_class), 32'd1);
        check("b2b_score",  32'(ifa.result_score), 32'd9);

        // ---------------- back-pressure in HOLD, beats ignored ----------------
        ifa.s_valid = 1'b1;
        ifa.s       = 20'hABCDE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_ready",  32'(ifa.s_ready),      32'd0);
            check("hold_rvalid", 32'(ifa.result_valid), 32'd1);
            check("hold_class",  32'(ifa.result_class), 32'd1);
            check("hold_score",  32'(ifa.result_score), 32'd9);
        end
        ifa.s_valid      = 1'b0;
        ifa.result_ready = 1'b1;
        tick();
        ifa.result_ready = 1'b0;
        check("release_rvalid", 32'(ifa.result_valid), 32'd0);
        check("release_ready",  32'(ifa.s_ready),      32'd1);
        check("accum_keeps_class", 32'(ifa.result_class), 32'd1);
        check("accum_keeps_score", 32'(ifa.result_score), 32'd9);

        // ---------------- same image with random gaps, scored from zero -------
        for (int i = 0; i < 9; i++) send_a_gap(img[i]);
        repeat (3) tick();
        check("gap_idle_rvalid", 32'(ifa.result_valid), 32'd0);
        check("gap_idle_class",  32'(ifa.result_class), 32'd1);
        send_a_gap(img[9]);
        check("gap_rvalid", 32'(ifa.result_valid), 32'd1);
        check("gap_class",  32'(ifa.result_class), 32'd1);
        check("gap_score",  32'(ifa.result_score), 32'd9);
        consume_a();

        // ---------------- reset mid-image ----------------
        for (int i = 0; i < 6; i++) send_a(20'hFFFFF);
        rst              = 1'b1;
        ifa.s_valid      = 1'b1;
        ifa.s            = 20'hFFFFF;
        ifa.result_ready = 1'b1;
        tick();
        rst              = 1'b0;
        ifa.s_valid      = 1'b0;
        ifa.result_ready = 1'b0;
        check("midrst_ready",  32'(ifa.s_ready),      32'd1);
        check("midrst_rvalid", 32'(ifa.result_valid), 32'd0);
        check("midrst_score",  32'(ifa.result_score), 32'd0);
        for (int i = 0; i < 10; i++) send_a((i == 7) ? 20'h12345 : 20'h0);
        check("postrst_rvalid", 32'(ifa.result_valid), 32'd1);
        check("postrst_class",  32'(ifa.result_class), 32'd7);
        check("postrst_score",  32'(ifa.result_score), 32'h12345);
        consume_a();

        // ---------------- CHUNKS=4, CLASSES=2 ----------------
        for (int i = 0; i < 4; i++) send_b(20'hFFFFF);
        for (int i = 1; i < 4; i++) send_b(20'(i));
        check("ch4_rvalid_before_last", 32'(ifb.result_valid), 32'd0);
        send_b(20'd4);
        check("ch4_rvalid", 32'(ifb.result_valid), 32'd1);
        check("ch4_class",  32'(ifb.result_class), 32'd0);
        check("ch4_score",  32'(ifb.result_score), 32'h3FFFFC);
        ifb.result_ready = 1'b1;
        tick();
        ifb.result_ready = 1'b0;
        // class 0 sums to 4, class 1 to 5: strictly greater later class wins
        for (int i = 0; i < 4; i++) send_b(20'd1);
        for (int i = 0; i < 3; i++) send_b(20'd0);
        send_b(20'd5);
        check("ch4_win1_class", 32'(ifb.result_class), 32'd1);
        check("ch4_win1_score", 32'(ifb.result_score), 32'd5);

        // ---------------- AW=20 overflow behaviour ----------------
`ifdef ACC_SAT_EN
        exp_c = 32'hFFFFF;
`else
        exp_c = 32'h00001;
`endif
        send_c(20'hFFFFF);
        send_c(20'h00002);
        send_c(20'h0);
        send_c(20'h0);
        check("ovf_rvalid", 32'(ifc.result_valid), 32'd1);
        check("ovf_class",  32'(ifc.result_class), 32'd0);
        check("ovf_score",  32'(ifc.result_score), exp_c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_argmax.md
MAC_ARGMAX -- requirements
Module: mac_argmax

Interface
REQ-001 Parameter: SW, 20, width of incoming MAC sum.
REQ-002 Parameter: AW, 24, width of per-class accumulator; AW SHALL be >= SW.
REQ-003 Parameter: CHUNKS, 1, MAC sums accumulated per class score (range 1..16).
REQ-004 Parameter: CLASSES, 10, class scores per image (range 2..16).
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  reset; one clock, synchronous and active-high.
REQ-007 Port: s_valid  input  1  s carries a valid MAC sum.
REQ-008 Port: s  input  SW  unsigned MAC sum from upstream mac1 stage.
REQ-009 Port: s_ready  output  1  block accepts s this cycle.
REQ-010 Port: result_valid  output  1  result_class/result_score valid.
REQ-011 Port: result_ready  input  1  downstream consumes result.
REQ-012 Port: result_class  output  4  index of winning class.
REQ-013 Port: result_score  output  AW  accumulated score of winning class.

Function
REQ-014 Beat is accepted when s_valid && s_ready at rising clk; beats are ordered class 0 chunk 0..CHUNKS-1, then class 1, and so on.
REQ-015 States: ACCUM (s_ready=1, result_valid=0) and HOLD (s_ready=0, result_valid=1); no other states.
REQ-016 ACCUM, accepted beat: acc <= acc + zero-extended s; chunk counter increments.
REQ-017 Accepted beat with chunk==CHUNKS-1: class score = acc + s (same cycle); acc and chunk clear; class counter increments.
REQ-018 Completed class score is compared unsigned against best: class 0 always loads best; later class replaces best only if strictly greater (ties keep lower index).
REQ-019 Accepted beat completing class CLASSES-1: next state HOLD; result_valid SHALL assert on the following cycle (latency 1 clock from final beat); class counter clears.
REQ-020 HOLD: result_class/result_score stable until handshake; s is ignored regardless of s_valid.
REQ-021 HOLD with result_ready=1: return to ACCUM next cycle; result_valid deasserts; s_ready reasserts (one-cycle bubble, no back-to-back accept in handshake cycle).
REQ-022 Cycles in ACCUM with s_valid=0 SHALL leave all state unchanged.
REQ-023 result_class/result_score SHALL be held at last result value while in ACCUM (not updated until next HOLD entry).
REQ-024 CHUNKS=1: every accepted beat completes a class score.

Reset
REQ-025 rst=1 at rising clk SHALL force ACCUM; acc, best, chunk and class counters, result_class, result_score to 0; s_ready=1 and result_valid=0 the cycle after.
REQ-026 rst mid-image or in HOLD SHALL discard partial scores and any unconsumed result; rst dominates s_valid and result_ready in the same cycle.

Configuration
REQ-027 Macro ACC_SAT_EN defined: acc + s exceeding 2^AW-1 SHALL saturate to 2^AW-1.
REQ-028 ACC_SAT_EN undefined: acc + s SHALL wrap modulo 2^AW; no overflow indication.

Verification
REQ-029 CHUNKS=1, CLASSES=10, scores 5,9,3,9,0,1,2,8,7,6 back-to-back -> result_valid one cycle after 10th beat, class 1, score 9 (tie resolves low).
REQ-030 CHUNKS=4, CLASSES=2, class0 chunks 0xFFFFF x4, class1 chunks 1,2,3,4 -> class 0, score 0x3FFFFC.
REQ-031 Hold result_ready=0 for 5 cycles with s_valid=1, s=0xABCDE -> s_ready=0, outputs stable, beats ignored; release -> s_ready=1 next cycle, next image scored from zero.
REQ-032 Assert rst after 6 of 10 beats, then send full image all scores 0 except class 7 = 0x12345 -> class 7, score 0x12345.
REQ-033 AW=20, CHUNKS=2, class0 chunks 0xFFFFF,0x00002: ACC_SAT_EN -> score 0xFFFFF; without -> score 0x00001.
REQ-034 Random s_valid gaps (50% duty) on REQ-029 data -> identical result to gap-free run.
